// File: rtl/sng_share_arb.sv
// Packet-granular round-robin arbiter sharing one SNG between NREQ requesters.
// A grant is held for a whole packet so the SNG's per-packet phase sequence stays coherent.
module sng_share_arb #(
    parameter int NREQ      = 4,
    parameter int QUANT     = 8,
    parameter int BITSTREAM = 64,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*QUANT-1:0]    req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [QUANT-1:0]         sng_w_data,
    output logic                     sng_w_valid,
    output logic                     sng_r_ready,
    output logic                     sng_wlast,
    input  logic [BITSTREAM-1:0]     sng_r_bitstream,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITSTREAM-1:0]     out_bitstream,
    output logic [$clog2(NREQ)-1:0]  out_id,
    output logic                     out_last,
    output logic                     out_trunc,
    output logic                     busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] pick_id;
    logic           pick_found;
    logic [CW-1:0]  beat_cnt;
    logic           lock;
    logic           can_acc;
    logic           fire;
    logic           force_end;
    logic           cur_last;
    logic           wlast;

    assign lock      = (state == S_LOCK);
    assign can_acc   = !out_valid || out_ready;
    assign cur_last  = req_last[grant_id];
    assign force_end = (beat_cnt == LAST_BEAT);
    assign wlast     = cur_last || force_end;
    assign fire      = lock && req_valid[grant_id] && can_acc;
    assign busy      = lock;

    // Round-robin scan starting one past the last packet's owner, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
                pick_found = 1'b1;
                pick_id    = IDW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready   = '0;
        sng_w_data  = '0;
        sng_w_valid = 1'b0;
        sng_r_ready = 1'b0;
        sng_wlast   = 1'b0;
        if (lock) begin
            req_ready[grant_id] = can_acc;
            sng_w_data          = req_data[grant_id*QUANT +: QUANT];
            sng_w_valid         = req_valid[grant_id];
            sng_r_ready         = can_acc;
            sng_wlast           = wlast;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rr_ptr   <= IDW'(NREQ - 1);
            grant_id <= '0;
            beat_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (pick_found) begin
                grant_id <= pick_id;
                state    <= S_LOCK;
            end
        end else if (fire) begin
            if (wlast) begin
                beat_cnt <= '0;
                rr_ptr   <= grant_id;
                state    <= S_IDLE;
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

    // A fire in the same cycle as out_ready reloads the register, so there is no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_bitstream <= '0;
            out_id        <= '0;
            out_last      <= 1'b0;
            out_trunc     <= 1'b0;
        end else if (fire) begin
            out_valid     <= 1'b1;
            out_bitstream <= sng_r_bitstream;
            out_id        <= grant_id;
            out_last      <= wlast;
            out_trunc     <= force_end && !cur_last;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sng_share_arb.sv
// Directed self-checking bench for sng_share_arb with a behavioural SNG (phase k cleared on wlast).
module tb_sng_share_arb;
    localparam int NREQ = 4;
    localparam int QUANT = 8;
    localparam int BITSTREAM = 64;
    localparam int MAX_BURST = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*QUANT-1:0]   req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    logic [QUANT-1:0]        sng_w_data;
    logic                    sng_w_valid;
    logic                    sng_r_ready;
    logic                    sng_wlast;
    logic [BITSTREAM-1:0]    sng_r_bitstream;
    logic                    out_valid;
    logic                    out_ready;
    logic [BITSTREAM-1:0]    out_bitstream;
    logic [1:0]              out_id;
    logic                    out_last;
    logic                    out_trunc;
    logic                    busy;

    sng_share_arb #(.NREQ(NREQ), .QUANT(QUANT), .BITSTREAM(BITSTREAM), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .sng_w_data(sng_w_data), .sng_w_valid(sng_w_valid), .sng_r_ready(sng_r_ready),
        .sng_wlast(sng_wlast), .sng_r_bitstream(sng_r_bitstream),
        .out_valid(out_valid), .out_ready(out_ready), .out_bitstream(out_bitstream),
        .out_id(out_id), .out_last(out_last), .out_trunc(out_trunc), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Thermometer code of the rounded unipolar count of v, rotated left by the phase k.
    function automatic logic [63:0] gen(input logic [7:0] v, input int k);
        int c;
        logic [63:0] t;
        c = (int'($signed(v)) + 130) >>> 2;
        t = (c >= 64) ? '1 : ((64'd1 << c) - 64'd1);
        return (k == 0) ? t : ((t << k) | (t >> (64 - k)));
    endfunction

    logic [1:0] sng_k;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sng_k <= '0;
        else if (sng_w_valid && sng_r_ready) sng_k <= sng_wlast ? 2'd0 : sng_k + 2'd1;
    end
    assign sng_r_bitstream = gen(sng_w_data, int'(sng_k));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] log_bs [256];
    logic [1:0]  log_id [256];
    logic        log_last [256];
    logic        log_trunc [256];
    int          n_out = 0;
    int          fire_cyc [256];
    logic        fire_wl [256];
    int          n_fire = 0;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && n_out < 256) begin
            log_bs[n_out]    = out_bitstream;
            log_id[n_out]    = out_id;
            log_last[n_out]  = out_last;
            log_trunc[n_out] = out_trunc;
            n_out = n_out + 1;
        end
        if (rst_n && sng_w_valid && sng_r_ready && n_fire < 256) begin
            fire_cyc[n_fire] = cyc;
            fire_wl[n_fire]  = sng_wlast;
            n_fire = n_fire + 1;
        end
    end

    logic [7:0]      bdata [NREQ][32];
    logic            blast [NREQ][32];
    int              bcnt [NREQ];
    int              bhead [NREQ];
    logic [NREQ-1:0] hold_off;
    int              n_checks = 0;
    int              n_pass = 0;

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (bhead[i] < bcnt[i] && !hold_off[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*QUANT +: QUANT] = bdata[i][bhead[i]];
                req_last[i] = blast[i][bhead[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*QUANT +: QUANT] = '0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        bdata[r][bcnt[r]] = d;
        blast[r][bcnt[r]] = l;
        bcnt[r] = bcnt[r] + 1;
    endtask

    task automatic step();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (hs[i]) bhead[i] = bhead[i] + 1;
        drive_inputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        hold_off = '0;
        for (int i = 0; i < NREQ; i++) begin
            bcnt[i] = 0;
            bhead[i] = 0;
        end
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int base, input int want, input int max_cyc, input string tag);
        int n = 0;
        while ((n_out - base) < want && n < max_cyc) begin
            step();
            n++;
        end
        n_checks++;
        if ((n_out - base) < want)
            $display("[TB] FAIL %s timeout: got %0d beats, want %0d", tag, n_out - base, want);
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_bitstream !== 64'd0) $display("[TB] FAIL reset out_bitstream got %h want 0", out_bitstream); else n_pass++;
        n_checks++; if (out_id !== 2'd0) $display("[TB] FAIL reset out_id got %0d want 0", out_id); else n_pass++;
        n_checks++; if ({out_last, out_trunc} !== 2'b00) $display("[TB] FAIL reset last/trunc got %b want 00", {out_last, out_trunc}); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset busy got %b want 0", busy); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL reset req_ready got %b want 0000", req_ready); else n_pass++;
        n_checks++; if ({sng_w_valid, sng_r_ready, sng_wlast} !== 3'b000) $display("[TB] FAIL reset sng ctl got %b want 000", {sng_w_valid, sng_r_ready, sng_wlast}); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int bo, bf, c0;
        int pc [3] = '{32, 0, 64};
        logic [7:0] v [3] = '{8'd0, 8'h80, 8'h7f};
        apply_reset();
        bo = n_out; bf = n_fire; c0 = cyc;
        for (int j = 0; j < 3; j++) push(0, v[j], j == 2);
        drive_inputs();
        drain(bo, 3, 20, "single");
        repeat (2) step();
        n_checks++; if (n_fire - bf !== 3) $display("[TB] FAIL single fire count got %0d want 3", n_fire - bf); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (fire_cyc[bf+j] !== c0 + 1 + j) $display("[TB] FAIL single fire%0d cycle got %0d want %0d", j, fire_cyc[bf+j], c0 + 1 + j); else n_pass++;
            n_checks++; if ($countones(log_bs[bo+j]) !== pc[j]) $display("[TB] FAIL single popcount%0d got %0d want %0d", j, $countones(log_bs[bo+j]), pc[j]); else n_pass++;
            n_checks++; if (log_bs[bo+j] !== gen(v[j], j)) $display("[TB] FAIL single bitstream%0d got %h want %h", j, log_bs[bo+j], gen(v[j], j)); else n_pass++;
            n_checks++; if ({log_id[bo+j], log_last[bo+j]} !== {2'd0, j == 2}) $display("[TB] FAIL single id/last%0d got %0d/%b want 0/%b", j, log_id[bo+j], log_last[bo+j], j == 2); else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        int bo, bf;
        int exp_id [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int exp_beat [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3};
        logic [7:0] v;
        apply_reset();
        bo = n_out; bf = n_fire;
        for (int r = 0; r < NREQ; r++)
            for (int j = 0; j < ((r == 0) ? 4 : 2); j++) push(r, 8'(r*32 + j*5 + 3), j[0]);
        drive_inputs();
        drain(bo, 10, 60, "round_robin");
        for (int n = 0; n < 10; n++) begin
            v = 8'(exp_id[n]*32 + exp_beat[n]*5 + 3);
            n_checks++; if (log_id[bo+n] !== 2'(exp_id[n])) $display("[TB] FAIL rr id%0d got %0d want %0d", n, log_id[bo+n], exp_id[n]); else n_pass++;
            n_checks++; if (log_bs[bo+n] !== gen(v, n % 2)) $display("[TB] FAIL rr bitstream%0d got %h want %h", n, log_bs[bo+n], gen(v, n % 2)); else n_pass++;
            n_checks++; if (log_last[bo+n] !== n[0]) $display("[TB] FAIL rr last%0d got %b want %b", n, log_last[bo+n], n[0]); else n_pass++;
        end
        for (int p = 0; p < 4; p++) begin
            n_checks++; if (fire_cyc[bf+2*p+2] - fire_cyc[bf+2*p+1] !== 2) $display("[TB] FAIL rr bubble%0d got gap %0d want 2", p, fire_cyc[bf+2*p+2] - fire_cyc[bf+2*p+1]); else n_pass++;
        end
    endtask

    task automatic test_max_burst();
        int bo, bf, ph;
        apply_reset();
        bo = n_out; bf = n_fire;
        for (int i = 0; i < 10; i++) push(2, 8'(8*(i+1)), 1'b0);
        drive_inputs();
        drain(bo, 10, 40, "max_burst");
        for (int i = 0; i < 10; i++) begin
            ph = (i < 8) ? i % 4 : i - 8;
            n_checks++; if (log_bs[bo+i] !== gen(8'(8*(i+1)), ph)) $display("[TB] FAIL burst bitstream%0d got %h want %h", i, log_bs[bo+i], gen(8'(8*(i+1)), ph)); else n_pass++;
            n_checks++; if ({log_id[bo+i], log_last[bo+i], log_trunc[bo+i]} !== {2'd2, i == 7, i == 7}) $display("[TB] FAIL burst id/last/trunc%0d got %0d/%b/%b want 2/%b/%b", i, log_id[bo+i], log_last[bo+i], log_trunc[bo+i], i == 7, i == 7); else n_pass++;
            n_checks++; if (fire_wl[bf+i] !== (i == 7)) $display("[TB] FAIL burst wlast%0d got %b want %b", i, fire_wl[bf+i], i == 7); else n_pass++;
        end
        n_checks++; if (fire_cyc[bf+8] - fire_cyc[bf+7] !== 2) $display("[TB] FAIL burst rearb gap got %0d want 2", fire_cyc[bf+8] - fire_cyc[bf+7]); else n_pass++;
    endtask

    task automatic test_backpressure();
        int bo;
        logic [7:0] v [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
        apply_reset();
        bo = n_out;
        for (int j = 0; j < 4; j++) push(0, v[j], j == 3);
        drive_inputs();
        repeat (2) step();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp out_valid c%0d got %b want 1", c, out_valid); else n_pass++;
            n_checks++; if (out_bitstream !== gen(v[0], 0)) $display("[TB] FAIL bp hold c%0d got %h want %h", c, out_bitstream, gen(v[0], 0)); else n_pass++;
            n_checks++; if (req_ready !== 4'b0000) $display("[TB] FAIL bp req_ready c%0d got %b want 0000", c, req_ready); else n_pass++;
            n_checks++; if (sng_r_ready !== 1'b0) $display("[TB] FAIL bp sng_r_ready c%0d got %b want 0", c, sng_r_ready); else n_pass++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain(bo, 4, 20, "backpressure");
        repeat (3) step();
        n_checks++; if (n_out - bo !== 4) $display("[TB] FAIL bp beat count got %0d want 4", n_out - bo); else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (log_bs[bo+j] !== gen(v[j], j)) $display("[TB] FAIL bp bitstream%0d got %h want %h", j, log_bs[bo+j], gen(v[j], j)); else n_pass++;
            n_checks++; if (log_last[bo+j] !== (j == 3)) $display("[TB] FAIL bp last%0d got %b want %b", j, log_last[bo+j], j == 3); else n_pass++;
        end
    endtask

    task automatic test_grant_hold();
        int bo;
        int exp_id [6] = '{1, 1, 1, 1, 3, 3};
        int exp_beat [6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0] v;
        apply_reset();
        bo = n_out;
        for (int j = 0; j < 4; j++) push(1, 8'(32 + j*5 + 3), j == 3);
        for (int j = 0; j < 2; j++) push(3, 8'(96 + j*5 + 3), j == 1);
        drive_inputs();
        repeat (3) step();
        hold_off[1] = 1'b1;
        drive_inputs();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if (busy !== 1'b1) $display("[TB] FAIL hold busy c%0d got %b want 1", c, busy); else n_pass++;
            n_checks++; if (req_ready !== 4'b0010) $display("[TB] FAIL hold req_ready c%0d got %b want 0010", c, req_ready); else n_pass++;
            n_checks++; if (sng_w_valid !== 1'b0) $display("[TB] FAIL hold sng_w_valid c%0d got %b want 0", c, sng_w_valid); else n_pass++;
            @(posedge clk);
            #1;
        end
        hold_off[1] = 1'b0;
        drive_inputs();
        drain(bo, 6, 30, "grant_hold");
        for (int n = 0; n < 6; n++) begin
            v = 8'(exp_id[n]*32 + exp_beat[n]*5 + 3);
            n_checks++; if (log_id[bo+n] !== 2'(exp_id[n])) $display("[TB] FAIL hold id%0d got %0d want %0d", n, log_id[bo+n], exp_id[n]); else n_pass++;
            n_checks++; if (log_bs[bo+n] !== gen(v, exp_beat[n])) $display("[TB] FAIL hold bitstream%0d got %h want %h", n, log_bs[bo+n], gen(v, exp_beat[n])); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_packet();
        int bo, n;
        int exp_id [3] = '{0, 0, 3};
        logic [7:0] v [3] = '{8'd50, 8'd55, 8'd99};
        int exp_ph [3] = '{0, 1, 0};
        apply_reset();
        push(1, 8'd3, 1'b0); push(1, 8'd8, 1'b1);
        push(2, 8'd67, 1'b0); push(2, 8'd72, 1'b0); push(2, 8'd77, 1'b1);
        drive_inputs();
        n = 0;
        while (bhead[2] < 1 && n < 30) begin
            step();
            n++;
        end
        n_checks++; if (bhead[2] < 1) $display("[TB] FAIL midrst timeout: req2 beats %0d want 1", bhead[2]); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, out_last, out_trunc, busy} !== 4'b0000) $display("[TB] FAIL midrst flags got %b want 0000", {out_valid, out_last, out_trunc, busy}); else n_pass++;
        n_checks++; if ({out_bitstream, out_id} !== 66'd0) $display("[TB] FAIL midrst data got %h/%0d want 0/0", out_bitstream, out_id); else n_pass++;
        n_checks++; if ({req_ready, sng_w_valid, sng_r_ready} !== 6'd0) $display("[TB] FAIL midrst handshake got %b want 000000", {req_ready, sng_w_valid, sng_r_ready}); else n_pass++;
        for (int i = 0; i < NREQ; i++) begin
            bcnt[i] = 0;
            bhead[i] = 0;
        end
        push(0, v[0], 1'b0); push(0, v[1], 1'b1); push(3, v[2], 1'b1);
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        bo = n_out;
        rst_n = 1'b1;
        drain(bo, 3, 20, "midrst");
        for (int j = 0; j < 3; j++) begin
            n_checks++; if (log_id[bo+j] !== 2'(exp_id[j])) $display("[TB] FAIL midrst id%0d got %0d want %0d", j, log_id[bo+j], exp_id[j]); else n_pass++;
            n_checks++; if (log_bs[bo+j] !== gen(v[j], exp_ph[j])) $display("[TB] FAIL midrst bitstream%0d got %h want %h", j, log_bs[bo+j], gen(v[j], exp_ph[j])); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_grant_hold();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
